// File: rtl/free_space_if.sv
// Gate-sensor / display-control bundle for the free-space counter.
// master drives the requests and observes status; slave is the counter itself.
interface free_space_if #(
  parameter int WIDTH = 8
);
  logic             entry_req;
  logic             exit_req;
  logic [WIDTH-1:0] free_count;
  logic             entry_ack;
  logic             entry_deny;
  logic             exit_err;
  logic             lot_full;
  logic             lot_empty;

  modport master (
    output entry_req, exit_req,
    input  free_count, entry_ack, entry_deny, exit_err, lot_full, lot_empty
  );

  modport slave (
    input  entry_req, exit_req,
    output free_count, entry_ack, entry_deny, exit_err, lot_full, lot_empty
  );
endinterface

// File: rtl/free_space_down_counter.sv
// Parking-lot free-space counter: grants/denies entries, flags illegal exits.
// Optional macro FREE_SPACE_STICKY_ERR_EN makes exit_err hold until reset.
module free_space_down_counter #(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 200
) (
  input  logic         clk,
  input  logic         reset,
  free_space_if.slave  bus
);

  localparam logic [WIDTH-1:0] CAP = CAPACITY[WIDTH-1:0];

  logic [WIDTH-1:0] free_q, free_d;
  logic [WIDTH-1:0] dec_w, inc_w;
  logic             ack_q, ack_d;
  logic             deny_q, deny_d;
  logic             err_q, err_d;
  logic             illegal_exit;

  // Returns {borrow_out, difference} of a - b - borrow_in.
  function automatic logic [1:0] full_subtractor(input logic a, input logic b,
                                                 input logic bin);
    logic diff;
    logic bout;
    diff = a ^ b ^ bin;
    bout = (~a & (b | bin)) | (b & bin);
    return {bout, diff};
  endfunction

  function automatic logic [1:0] full_adder(input logic a, input logic b,
                                            input logic cin);
    logic sum;
    logic cout;
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
    return {cout, sum};
  endfunction

  // Final borrow/carry are dropped: the guards never let F-1 or F+1 wrap.
  always_comb begin
    logic bw;
    logic cy;
    bw    = 1'b1;
    cy    = 1'b1;
    dec_w = '0;
    inc_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {bw, dec_w[i]} = full_subtractor(free_q[i], 1'b0, bw);
      {cy, inc_w[i]} = full_adder(free_q[i], 1'b0, cy);
    end
  end

  always_comb begin
    free_d       = free_q;
    ack_d        = 1'b0;
    deny_d       = 1'b0;
    illegal_exit = 1'b0;
    case ({bus.entry_req, bus.exit_req})
      2'b10: begin
        if (free_q != '0) begin
          free_d = dec_w;
          ack_d  = 1'b1;
        end else begin
          deny_d = 1'b1;
        end
      end
      2'b01: begin
        if (free_q != CAP) free_d = inc_w;
        else               illegal_exit = 1'b1;
      end
      2'b11:   ack_d = 1'b1;
      default: ;
    endcase
  end

`ifdef FREE_SPACE_STICKY_ERR_EN
  assign err_d = err_q | illegal_exit;
`else
  assign err_d = illegal_exit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q <= CAP;
      ack_q  <= 1'b0;
      deny_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      ack_q  <= ack_d;
      deny_q <= deny_d;
      err_q  <= err_d;
    end
  end

  assign bus.free_count = free_q;
  assign bus.entry_ack  = ack_q;
  assign bus.entry_deny = deny_q;
  assign bus.exit_err   = err_q;
  assign bus.lot_full   = (free_q == '0);
  assign bus.lot_empty  = (free_q == CAP);

endmodule

// File: tb/tb_free_space_down_counter.sv
// Scoreboard bench: two counters (CAPACITY 200 and 2) driven by directed steps;
// a negedge monitor pops expected responses and compares them with the outputs.
module tb_free_space_down_counter;

`ifdef FREE_SPACE_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst_a, rst_b;

  free_space_if #(.WIDTH(8)) bus_a ();
  free_space_if #(.WIDTH(8)) bus_b ();

  free_space_down_counter #(.WIDTH(8), .CAPACITY(200)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  free_space_down_counter #(.WIDTH(8), .CAPACITY(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sel;   // 0: dut_a (CAP 200), 1: dut_b (CAP 2)
    int fc;
    bit ack;
    bit deny;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic cmp(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   cap;
      e   = exp_q.pop_front();
      cap = e.sel ? 2 : 200;
      if (!e.sel) begin
        cmp("a_free_count", int'(bus_a.free_count), e.fc);
        cmp("a_entry_ack",  int'(bus_a.entry_ack),  int'(e.ack));
        cmp("a_entry_deny", int'(bus_a.entry_deny), int'(e.deny));
        cmp("a_exit_err",   int'(bus_a.exit_err),   int'(e.err));
        cmp("a_lot_full",   int'(bus_a.lot_full),   int'(e.fc == 0));
        cmp("a_lot_empty",  int'(bus_a.lot_empty),  int'(e.fc == cap));
      end else begin
        cmp("b_free_count", int'(bus_b.free_count), e.fc);
        cmp("b_entry_ack",  int'(bus_b.entry_ack),  int'(e.ack));
        cmp("b_entry_deny", int'(bus_b.entry_deny), int'(e.deny));
        cmp("b_exit_err",   int'(bus_b.exit_err),   int'(e.err));
        cmp("b_lot_full",   int'(bus_b.lot_full),   int'(e.fc == 0));
        cmp("b_lot_empty",  int'(bus_b.lot_empty),  int'(e.fc == cap));
      end
    end
  end

  // One clocked request on the selected counter; the other sits idle.
  task automatic step(input bit sel, input bit rst, input bit er, input bit xr,
                      input int fc, input bit ack, input bit deny, input bit err);
    exp_t e;
    @(negedge clk);
    rst_a = sel ? 1'b0 : rst;
    rst_b = sel ? rst  : 1'b0;
    bus_a.entry_req = sel ? 1'b0 : er;
    bus_a.exit_req  = sel ? 1'b0 : xr;
    bus_b.entry_req = sel ? er   : 1'b0;
    bus_b.exit_req  = sel ? xr   : 1'b0;
    @(posedge clk);
    #1;
    e.sel = sel; e.fc = fc; e.ack = ack; e.deny = deny; e.err = err;
    exp_q.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.entry_req = 1'b0; bus_a.exit_req = 1'b0;
    bus_b.entry_req = 1'b0; bus_b.exit_req = 1'b0;

    // T1: reset both counters for two cycles
    step(0, 1, 0, 0, 200, 0, 0, 0);
    step(0, 1, 0, 0, 200, 0, 0, 0);
    step(1, 1, 0, 0, 2,   0, 0, 0);
    step(1, 1, 0, 0, 2,   0, 0, 0);

    // T2: three back-to-back entries
    step(0, 0, 1, 0, 199, 1, 0, 0);
    step(0, 0, 1, 0, 198, 1, 0, 0);
    step(0, 0, 1, 0, 197, 1, 0, 0);
    step(0, 0, 0, 0, 197, 0, 0, 0);
    // exits back up to capacity
    step(0, 0, 0, 1, 198, 0, 0, 0);
    step(0, 0, 0, 1, 199, 0, 0, 0);
    step(0, 0, 0, 1, 200, 0, 0, 0);
    // T5b: swap at capacity, no exit_err
    step(0, 0, 1, 1, 200, 1, 0, 0);
    // T4: exit at capacity
    step(0, 0, 0, 1, 200, 0, 0, 1);
    step(0, 0, 0, 0, 200, 0, 0, STICKY);
    step(0, 0, 1, 0, 199, 1, 0, STICKY);
    // drive down to 150
    for (int i = 0; i < 49; i++)
      step(0, 0, 1, 0, 198 - i, 1, 0, STICKY);
    step(0, 0, 0, 0, 150, 0, 0, STICKY);
    // T6: entry coincident with reset
    step(0, 1, 1, 0, 200, 0, 0, 0);
    step(0, 0, 0, 0, 200, 0, 0, 0);

    // T3: small lot fills up
    step(1, 0, 1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0, 1, 0);
    // T5a: swap at full lot
    step(1, 0, 1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 1);
    step(1, 0, 0, 0, 2, 0, 0, STICKY);
    step(1, 1, 0, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0, 2, 0, 0, 0);

    @(negedge clk);
    bus_b.exit_req = 1'b0;
    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
